// File: rtl/serial_bit_sequence_encoder.sv
// Serializes 3-bit symbols MSB-first in back-to-back 3-cycle groups fed from a small FIFO.
// Symbol 3'b111 is never sent: it is dropped on input and IDLE_SYMBOL fills empty slots.
module serial_bit_sequence_encoder #(
   parameter int         DEPTH       = 4,
   parameter logic [2:0] IDLE_SYMBOL = 3'b000
) (
   input  logic                   clk,
   input  logic                   n_reset,
   input  logic [2:0]             in_symbol,
   input  logic                   in_valid,
   output logic                   in_ready,
   output logic                   out_bit,
   output logic                   group_start,
   output logic                   idle_fill,
   output logic                   illegal_symbol,
   output logic [$clog2(DEPTH):0] fifo_count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   if (IDLE_SYMBOL == 3'b111) begin : g_bad_idle
      $error("IDLE_SYMBOL must not be 3'b111");
   end
   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("DEPTH must be a power of 2 and at least 2");
   end

   typedef enum logic [1:0] {
      PH_BIT2 = 2'd0,
      PH_BIT1 = 2'd1,
      PH_BIT0 = 2'd2
   } phase_t;

   phase_t          phase_q, phase_d;
   logic [2:0]      shreg_q, shreg_d;
   logic            out_bit_q, out_bit_d;
   logic            group_start_q, group_start_d;
   logic            idle_fill_q, idle_fill_d;
   logic            illegal_q, illegal_d;
   logic [CW-1:0]   count_q, count_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [2:0]      mem_q [DEPTH];
   logic [2:0]      mem_d [DEPTH];

   logic            xfer, push, pop;
   logic [2:0]      next_sym;

   // Handshake: a transfer happens on any rising edge where in_valid and in_ready are both
   // high; in_ready depends only on the registered count, so a pop cannot free a full slot early.
   assign in_ready = (count_q < CW'(DEPTH));

   always_comb begin
      xfer     = in_valid && in_ready;
      push     = xfer && (in_symbol != 3'b111);
      pop      = (phase_q == PH_BIT2) && (count_q != '0);
      next_sym = pop ? mem_q[rd_ptr_q] : IDLE_SYMBOL;

      phase_d       = phase_q;
      shreg_d       = shreg_q;
      out_bit_d     = out_bit_q;
      group_start_d = group_start_q;
      idle_fill_d   = idle_fill_q;
      illegal_d     = xfer && (in_symbol == 3'b111);

      mem_d = mem_q;
      if (push) begin
         mem_d[wr_ptr_q] = in_symbol;
      end
      wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      count_d  = count_q + CW'(push) - CW'(pop);

      case (phase_q)
         PH_BIT2: begin
            out_bit_d     = next_sym[2];
            shreg_d       = next_sym;
            group_start_d = 1'b1;
            idle_fill_d   = !pop;
            phase_d       = PH_BIT1;
         end
         PH_BIT1: begin
            out_bit_d     = shreg_q[1];
            group_start_d = 1'b0;
            idle_fill_d   = 1'b0;
            phase_d       = PH_BIT0;
         end
         PH_BIT0: begin
            out_bit_d     = shreg_q[0];
            group_start_d = 1'b0;
            idle_fill_d   = 1'b0;
            phase_d       = PH_BIT2;
         end
         default: begin
            phase_d = PH_BIT2;
         end
      endcase
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         phase_q       <= PH_BIT2;
         shreg_q       <= '0;
         out_bit_q     <= 1'b0;
         group_start_q <= 1'b0;
         idle_fill_q   <= 1'b0;
         illegal_q     <= 1'b0;
         count_q       <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         mem_q         <= '{default: '0};
      end else begin
         phase_q       <= phase_d;
         shreg_q       <= shreg_d;
         out_bit_q     <= out_bit_d;
         group_start_q <= group_start_d;
         idle_fill_q   <= idle_fill_d;
         illegal_q     <= illegal_d;
         count_q       <= count_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         mem_q         <= mem_d;
      end
   end

   assign out_bit        = out_bit_q;
   assign group_start    = group_start_q;
   assign idle_fill      = idle_fill_q;
   assign illegal_symbol = illegal_q;
   assign fifo_count     = count_q;

endmodule

// File: doc/serial_bit_sequence_encoder.md
Name: serial_bit_sequence_encoder

Overview:
Transmit-side partner of the team's serial 3-bit group checker. It accepts 3-bit symbols over a valid/ready handshake and buffers them in a small FIFO. It serializes each symbol MSB-first, one bit per clock, in back-to-back 3-cycle groups. The forbidden group 3'b111 is never emitted, and an idle filler symbol is sent whenever the FIFO is empty, so group alignment is never lost.

Parameters:
DEPTH, 4, FIFO depth in symbols; power of 2, minimum 2.
IDLE_SYMBOL, 3'b000, group sent when no data is queued; 3'b111 is an elaboration error.

Ports:
clk  input  1  rising-edge clock
n_reset  input  1  asynchronous, active-low reset
in_symbol  input  3  symbol to transmit
in_valid  input  1  in_symbol is valid this cycle
in_ready  output  1  encoder can accept a symbol; in_valid & in_ready = transfer
out_bit  output  1  serial line, registered
group_start  output  1  high during the cycle out_bit carries bit 2 (first bit) of a group
idle_fill  output  1  high alongside group_start when the group is IDLE_SYMBOL filler
illegal_symbol  output  1  one-cycle pulse: a 3'b111 transfer was dropped
fifo_count  output  $clog2(DEPTH)+1  symbols currently queued

Behaviour:
- Reset (n_reset low, async): FIFO empties immediately and outputs clear at once: fifo_count=0, bit_cnt=0, out_bit=0, group_start=0, idle_fill=0, illegal_symbol=0, in_ready=1. Reset mid-group drops the partial group and all queued symbols.
- in_ready = (fifo_count < DEPTH), combinational from registered count.
  - A push while full is not accepted, even if a pop happens in the same cycle.
- Transfer of a legal symbol (≠3'b111) writes it at the FIFO tail; fifo_count increments at that edge.
- Transfer of 3'b111:
  - the handshake completes (in_ready unaffected);
  - the symbol is discarded and the FIFO is unchanged;
  - illegal_symbol=1 for exactly the following cycle.
  - Back-to-back 111 transfers give consecutive pulses.
- Serializer: bit_cnt cycles 0→1→2→0 on every edge after reset release; shreg is 3 bits.
  - bit_cnt==0:
    - S = FIFO head if fifo_count>0 before this edge, and the head is popped; otherwise S = IDLE_SYMBOL.
    - out_bit<=S[2], shreg<=S, group_start<=1, idle_fill<=(FIFO was empty), bit_cnt<=1.
  - bit_cnt==1: out_bit<=shreg[1], group_start<=0, idle_fill<=0, bit_cnt<=2.
  - bit_cnt==2: out_bit<=shreg[0], bit_cnt<=0.
- No bypass: a symbol pushed at edge E is poppable no earlier than edge E+1.
  - Latency from accepting edge to the first bit on out_bit: 1 to 3 cycles, for an empty FIFO.
- Push and pop on the same edge: count unchanged; both take effect.
- FIFO pointers wrap modulo DEPTH; fifo_count is never greater than DEPTH and never below 0.
- First group after reset release starts at the first rising edge with n_reset high.
  - group_start is high every third cycle thereafter, with no gaps.
- The output stream never contains 3'b111 inside any group.

Test Plan:
- Idle after reset: no in_valid for 12 cycles.
  - Required: out_bit=0 throughout.
  - Required: group_start and idle_fill high on cycles 1,4,7,10 after release.
  - Required: fifo_count=0, in_ready=1.
- Single symbol: push 3'b101 once.
  - Required: the next group is 1,0,1 with group_start=1 and idle_fill=0 on its first bit.
  - Required: the following group is IDLE 0,0,0 with idle_fill=1.
  - Required: fifo_count returns 1→0 at the pop edge.
- Illegal symbol: push 3'b111.
  - Required: in_ready stays 1 and illegal_symbol=1 for exactly one cycle.
  - Required: fifo_count stays 0 and no 1,1,1 group appears.
  - Then push 3'b011: required group 0,1,1.
- Full FIFO: push 110, 011, 100, 010 on consecutive cycles, then hold 001 valid.
  - Required: in_ready=0 once fifo_count=4.
  - Required: 001 is accepted only after the first pop.
  - Required serial order: 110 011 100 010 001, each group contiguous, no filler between them.
- Reset mid-group: assert n_reset low during bit_cnt==1 with 3 symbols queued.
  - Required: out_bit=0, fifo_count=0, group_start=0 immediately, without waiting for a clock.
  - Required: after release, the first group is IDLE with group_start on edge 1.
- Random soak: 2000 cycles of random in_valid/in_symbol, including 111.
  - Required: the scoreboard matches every legal accepted symbol in order.
  - Required: the count of dropped symbols equals the count of illegal_symbol pulses.
  - Required: a group checker sees no 1,1,1 group.
